// File: rtl/uart_cmd_rx.sv
// rtl/uart_cmd_rx.sv - 8N1 UART receiver and ASCII drive/difficulty command decoder
// Optional link watchdog enabled by defining CMD_RX_WATCHDOG_EN.
module uart_cmd_rx #(
    parameter int CLK_FREQ        = 50_000_000,
    parameter int BAUD            = 9600,
    parameter int WATCHDOG_CYCLES = 25_000_000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       uart_in,
    output logic [2:0] cmd,
    output logic [2:0] difficulty,
    output logic       cmd_valid,
    input  logic       cmd_ready,
    output logic       frame_err,
    output logic       bad_cmd,
    output logic       overrun,
    output logic       timeout
);
    localparam int CPB = CLK_FREQ / BAUD;
    localparam int HALF = CPB / 2;
    localparam int CW = $clog2(CPB + 1);
    localparam logic [CW-1:0] CPB_LAST = CW'(CPB - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);

    if (CPB < 4 || WATCHDOG_CYCLES < 1) begin : g_param_check
        $error("uart_cmd_rx: CLK_FREQ/BAUD must be >= 4 and WATCHDOG_CYCLES >= 1");
    end

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, DECODE} state_t;

    state_t        state;
    logic          sync1, sync2, rx_d;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;

    logic       dec_drive, dec_digit, dec_ok;
    logic [2:0] dec_cmd, dec_diff;
    logic       load_cmd;
    logic [2:0] load_val;
    logic       wd_fire;

    always_comb begin
        dec_drive = 1'b1;
        dec_digit = 1'b0;
        dec_cmd   = 3'd0;
        dec_diff  = 3'd1;
        case (shreg)
            8'h53: dec_cmd = 3'd0;
            8'h46: dec_cmd = 3'd1;
            8'h42: dec_cmd = 3'd2;
            8'h4C: dec_cmd = 3'd3;
            8'h52: dec_cmd = 3'd4;
            8'h31, 8'h32, 8'h33, 8'h34, 8'h35: begin
                dec_drive = 1'b0;
                dec_digit = 1'b1;
                dec_diff  = shreg[2:0];
            end
            default: dec_drive = 1'b0;
        endcase
        dec_ok = dec_drive | dec_digit;
    end

`ifdef CMD_RX_WATCHDOG_EN
    localparam int WW = $clog2(WATCHDOG_CYCLES + 1);
    localparam logic [WW-1:0] WD_LAST = WW'(WATCHDOG_CYCLES - 1);
    logic [WW-1:0] wd_cnt;

    // A successful decode in the same cycle takes priority over expiry.
    assign wd_fire = (wd_cnt == WD_LAST) && !(state == DECODE && dec_ok);

    always_ff @(posedge clk) begin
        if (!reset_n)
            wd_cnt <= '0;
        else if ((state == DECODE && dec_ok) || wd_fire)
            wd_cnt <= '0;
        else
            wd_cnt <= wd_cnt + 1'b1;
    end
`else
    assign wd_fire = 1'b0;
`endif

    always_comb begin
        load_cmd = 1'b0;
        load_val = 3'd0;
        if (state == DECODE && dec_drive) begin
            load_cmd = 1'b1;
            load_val = dec_cmd;
        end else if (wd_fire) begin
            load_cmd = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            sync1      <= 1'b1;
            sync2      <= 1'b1;
            rx_d       <= 1'b1;
            cnt        <= '0;
            bit_idx    <= 3'd0;
            shreg      <= 8'd0;
            cmd        <= 3'd0;
            difficulty <= 3'd1;
            cmd_valid  <= 1'b0;
            frame_err  <= 1'b0;
            bad_cmd    <= 1'b0;
            overrun    <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            sync1     <= uart_in;
            sync2     <= sync1;
            rx_d      <= sync2;
            frame_err <= 1'b0;
            bad_cmd   <= 1'b0;
            overrun   <= 1'b0;
            timeout   <= wd_fire;

            // A load during a handshake cycle replaces the consumed command silently.
            if (load_cmd) begin
                cmd       <= load_val;
                cmd_valid <= 1'b1;
                overrun   <= cmd_valid && !cmd_ready;
            end else if (cmd_valid && cmd_ready) begin
                cmd_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    // Edge detect means a line held low after a framing error never re-arms.
                    if (rx_d && !sync2) begin
                        state <= START;
                        cnt   <= '0;
                    end
                end
                START: begin
                    if (cnt == HALF_LAST) begin
                        cnt     <= '0;
                        bit_idx <= 3'd0;
                        state   <= sync2 ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == CPB_LAST) begin
                        cnt     <= '0;
                        shreg   <= {sync2, shreg[7:1]};
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7)
                            state <= STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt == CPB_LAST) begin
                        cnt <= '0;
                        if (sync2) begin
                            state <= DECODE;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= IDLE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DECODE: begin
                    state   <= IDLE;
                    bad_cmd <= !dec_ok;
                    if (dec_digit)
                        difficulty <= dec_diff;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
